// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port single-memory arbiter.
// Holds the FSM state encoding, the port owner encoding, the latched
// transaction record and the default memory read latency.
package mem_arb_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  // Read latency from the mem_en cycle to valid mem_rdata; legal 1..4.
  localparam int MEM_LAT_DEFAULT = 1;
  // Wait counter holds MEM_LAT-1, so 0..3 fits in two bits.
  localparam int CNT_W           = 2;

  // Encoding is visible on the y debug output and must stay fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  // One latched memory transaction as captured from the winning port.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter giving a CPU port and an external loader/debug
//           port shared access to one single-port synchronous memory.
// Latency : request seen in IDLE at t -> write ack at t+2, read ack at t+2+MEM_LAT.
// Backpr. : requesters hold req until their one-cycle ack; cpu_stall mirrors
//           the CPU wait. Only one transaction is ever in flight.
// Ports   : clk/reset (sync, active-high); cpu_* and ext_* request ports with
//           ack/rdata returns; mem_* memory strobe/address/data; cpu_stall;
//           y = current FSM state for debug.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // External loader/debug port
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  // Memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Debug
  output logic [1:0]        y
);

  // Value loaded into the wait counter when a read leaves ACCESS.
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  owner_t            r_last_owner;
  txn_t              r_txn;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ext_rdata;

  logic              w_any_req;
  owner_t            w_pick;
  txn_t              w_cpu_txn;
  txn_t              w_ext_txn;
  logic              w_in_resp;
  logic [DATA_W-1:0] w_resp_dat;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, round-robin pick and all outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_any_req   = cpu_req | ext_req;
    w_cpu_txn   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    w_ext_txn   = '{we: ext_we, addr: ext_addr, wdata: ext_wdata};

    // Under contention the port that was served last loses; a lone
    // requester always wins regardless of history.
    w_pick = OWN_CPU;
    if (cpu_req && ext_req) begin
      w_pick = (r_last_owner == OWN_CPU) ? OWN_EXT : OWN_CPU;
    end else if (ext_req) begin
      w_pick = OWN_EXT;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = r_txn.we ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // The memory strobe exists only in ACCESS, so a transaction can never
    // issue more than one memory cycle even if reset lands mid-flight.
    mem_en    = (r_state == ST_ACCESS);
    mem_we    = (r_state == ST_ACCESS) & r_txn.we;
    mem_addr  = r_txn.addr;
    mem_wdata = r_txn.wdata;

    // Writes return zero data; reads return what WAIT captured.
    w_in_resp  = (r_state == ST_RESP);
    w_resp_dat = r_txn.we ? '0 : r_rdata;

    cpu_ack = w_in_resp & (r_owner == OWN_CPU);
    ext_ack = w_in_resp & (r_owner == OWN_EXT);

    // Response data is visible in the ack cycle itself and is then held
    // in the per-port register, so the other port's value never moves.
    cpu_rdata = cpu_ack ? w_resp_dat : r_cpu_rdata;
    ext_rdata = ext_ack ? w_resp_dat : r_ext_rdata;

    cpu_stall = cpu_req & ~cpu_ack;
    y         = r_state;
  end

  // --------------------------------------------------------------------------
  // Transaction latch, wait counter and read-data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txn        <= '0;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_EXT;  // CPU wins the first contention after reset
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_cpu_rdata  <= '0;
      r_ext_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_pick;
            r_txn   <= (w_pick == OWN_EXT) ? w_ext_txn : w_cpu_txn;
          end
        end
        ST_ACCESS: begin
          if (!r_txn.we) begin
            r_cnt <= LAT_INIT;
          end
        end
        ST_WAIT: begin
          // Counter reaching zero marks the cycle the memory data is valid.
          if (r_cnt == '0) begin
            r_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_last_owner <= r_owner;
          if (r_owner == OWN_CPU) begin
            r_cpu_rdata <= w_resp_dat;
          end else begin
            r_ext_rdata <= w_resp_dat;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule
